int_request_conditioner: RTL and testbench

Conditions three asynchronous external interrupt sources (board buttons/switches) into clean, single-event interrupt requests for the interrupt coprocessor's `int0`/`int1`/`int2` inputs. Per channel it synchronizes, optionally debounces and detects rising edges. It holds each detected event pending until the core is enabled, so an event raised while the core is halted is delivered, not lost. It sits between the top-level pins and the coprocessor, in the CPU clock domain.

---
 rtl/int_request_conditioner_pkg.sv | 7 +
 rtl/int_request_conditioner_if.sv | 9 +
 rtl/int_request_conditioner_chan.sv | 49 ++++
 rtl/int_request_conditioner.sv | 35 +++
 tb/tb_int_request_conditioner.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/int_request_conditioner_pkg.sv
// int_request_conditioner_pkg: shared channel count, debounce defaults and vector type
package int_request_conditioner_pkg;
  localparam int N_CH = 3;
  localparam int DB_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT = 20;
  typedef logic [N_CH-1:0] ch_vec_t;
endpackage

// File: rtl/int_request_conditioner_if.sv
// int_request_conditioner_if: enable, raw sources and conditioned outputs between pins and coprocessor
interface int_request_conditioner_if;
  logic en;
  int_request_conditioner_pkg::ch_vec_t raw_in;
  int_request_conditioner_pkg::ch_vec_t int_req;
  int_request_conditioner_pkg::ch_vec_t level;
  modport master (output en, raw_in, input int_req, level);
  modport slave (input en, raw_in, output int_req, level);
endinterface

// File: rtl/int_request_conditioner_chan.sv
// int_channel_cond: one channel of sync, debounce (INT_DEBOUNCE_EN) or bypass, rise detect and pending bit
module int_channel_cond
  import int_request_conditioner_pkg::*;
#(
`ifdef INT_DEBOUNCE_EN
  parameter int DB_CYCLES = DB_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
`endif
  parameter logic INV = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_raw,
  output logic o_req,
  output logic o_level
);
  logic r_s1, r_s2, r_level, r_req;
  logic w_level_nxt, w_rise;
`ifdef INT_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt;
  // count consecutive cycles the synchronized input disagrees with the accepted level
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else r_cnt <= (r_s2 == r_level || r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
  end
  assign w_level_nxt = (r_s2 != r_level && r_cnt == LAST) ? r_s2 : r_level;
`else
  assign w_level_nxt = r_s2;
`endif
  assign w_rise = w_level_nxt & ~r_level;
  // two-flop synchronizer, accepted level and pending request; a new rise beats consumption
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_level <= 1'b0;
      r_req <= 1'b0;
    end else begin
      r_s1 <= i_raw ^ INV;
      r_s2 <= r_s1;
      r_level <= w_level_nxt;
      r_req <= w_rise | (r_req & ~i_en);
    end
  end
  assign o_req = r_req;
  assign o_level = r_level;
endmodule

// File: rtl/int_request_conditioner.sv
// int_request_conditioner: three independent interrupt channels; debounce enabled by INT_DEBOUNCE_EN
module int_request_conditioner
  import int_request_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter logic [N_CH-1:0] IN_INV = '0
) (
  input logic clk,
  input logic rst,
  int_request_conditioner_if.slave io_bus
);
  ch_vec_t w_req, w_level;
  if (DB_CYCLES < 1 || DB_CYCLES > (1 << CNT_W) - 1) begin : g_bad_db
    $error("DB_CYCLES must lie in 1..2**CNT_W-1");
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    int_channel_cond #(
`ifdef INT_DEBOUNCE_EN
      .DB_CYCLES(DB_CYCLES),
      .CNT_W(CNT_W),
`endif
      .INV(IN_INV[i])
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .i_en(io_bus.en),
      .i_raw(io_bus.raw_in[i]),
      .o_req(w_req[i]),
      .o_level(w_level[i])
    );
  end
  assign io_bus.int_req = w_req;
  assign io_bus.level = w_level;
endmodule

// File: tb/tb_int_request_conditioner.sv
// tb_int_request_conditioner: directed stimulus with a sample-history model checked every cycle
module tb_int_request_conditioner;
  localparam int DB = 4;
  localparam logic [2:0] INV = 3'b001;
`ifdef INT_DEBOUNCE_EN
  localparam int W = DB;
`else
  localparam int W = 1;
`endif
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  int_request_conditioner_if bus();
  int_request_conditioner #(.DB_CYCLES(DB), .CNT_W(3), .IN_INV(INV)) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // model: level flips once the last W synchronized samples all differ from it
  initial begin
    logic [2:0] h [8];
    logic [2:0] m_lvl, m_req, r;
    logic rs, e, f, nl;
    m_lvl = '0;
    m_req = '0;
    for (int i = 0; i < 8; i++) h[i] = '0;
    forever begin
      @(posedge clk);
      rs = rst;
      e = bus.en;
      r = bus.raw_in;
      @(negedge clk);
      if (rs) begin
        for (int i = 0; i < 8; i++) h[i] = '0;
        m_lvl = '0;
        m_req = '0;
      end else begin
        for (int i = 7; i > 0; i--) h[i] = h[i-1];
        h[0] = r ^ INV;
        for (int c = 0; c < 3; c++) begin
          f = 1'b1;
          for (int i = 2; i <= W + 1; i++) if (h[i][c] == m_lvl[c]) f = 1'b0;
          nl = f ? ~m_lvl[c] : m_lvl[c];
          m_req[c] = (nl & ~m_lvl[c]) ? 1'b1 : (e & m_req[c]) ? 1'b0 : m_req[c];
          m_lvl[c] = nl;
        end
      end
      chk("model_int_req", bus.int_req, m_req);
      chk("model_level", bus.level, m_lvl);
    end
  end

  task automatic drive(input logic rs, input logic e, input logic [2:0] r);
    rst = rs;
    bus.en = e;
    bus.raw_in = r;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input string name, input logic [2:0] m);
    for (int j = 1; j <= W + 3; j++) begin
      @(negedge clk);
      chk(name, bus.int_req & m, (j == W + 2) ? m : 3'b000);
    end
  endtask

  initial begin
    drive(1'b1, 1'b1, 3'b110);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("reset_int_req", bus.int_req, 3'b000);
      chk("reset_level", bus.level, 3'b000);
    end
    drive(1'b0, 1'b1, 3'b110);
    expect_pulse("all_rise", 3'b111);
    chk("all_level", bus.level, 3'b111);
    drive(1'b0, 1'b1, 3'b001);
    cycles(W + 4);
    chk("release_level", bus.level, 3'b000);
    chk("release_int_req", bus.int_req, 3'b000);
    drive(1'b0, 1'b1, 3'b000);
    expect_pulse("clean_press", 3'b001);
    chk("clean_level", bus.level & 3'b001, 3'b001);
    drive(1'b0, 1'b1, 3'b001);
    cycles(W + 4);
`ifdef INT_DEBOUNCE_EN
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 1'b1, (j % 2 == 0) ? 3'b011 : 3'b001);
      @(negedge clk);
    end
    drive(1'b0, 1'b1, 3'b011);
    expect_pulse("bounce", 3'b010);
    drive(1'b0, 1'b1, 3'b001);
    cycles(W + 4);
    drive(1'b0, 1'b1, 3'b011);
    cycles(3);
    drive(1'b0, 1'b1, 3'b001);
    for (int j = 0; j < W + 4; j++) begin
      @(negedge clk);
      chk("glitch3", bus.int_req & 3'b010, 3'b000);
    end
`else
    drive(1'b0, 1'b1, 3'b011);
    @(negedge clk);
    chk("glitch1_e1", bus.int_req & 3'b010, 3'b000);
    drive(1'b0, 1'b1, 3'b001);
    @(negedge clk);
    chk("glitch1_e2", bus.int_req & 3'b010, 3'b000);
    @(negedge clk);
    chk("glitch1_e3", bus.int_req & 3'b010, 3'b010);
    @(negedge clk);
    chk("glitch1_e4", bus.int_req & 3'b010, 3'b000);
`endif
    drive(1'b0, 1'b0, 3'b101);
    cycles(10);
    chk("halted_hold", bus.int_req & 3'b100, 3'b100);
    drive(1'b0, 1'b1, 3'b101);
    @(negedge clk);
    chk("halted_consume", bus.int_req & 3'b100, 3'b000);
    drive(1'b0, 1'b1, 3'b001);
    cycles(W + 4);
    drive(1'b0, 1'b0, 3'b000);
    cycles(W + 3);
    chk("pend0_set", bus.int_req & 3'b001, 3'b001);
    drive(1'b0, 1'b0, 3'b001);
    cycles(W + 3);
    chk("pend0_fall_level", bus.level & 3'b001, 3'b000);
    chk("pend0_keep", bus.int_req & 3'b001, 3'b001);
    drive(1'b0, 1'b0, 3'b000);
    cycles(W + 1);
    drive(1'b0, 1'b1, 3'b000);
    @(negedge clk);
    chk("rise_on_consume", bus.int_req & 3'b001, 3'b001);
    @(negedge clk);
    chk("consumed_next", bus.int_req & 3'b001, 3'b000);
    drive(1'b0, 1'b0, 3'b010);
    cycles(W + 3);
    chk("pend1_set", bus.int_req & 3'b010, 3'b010);
    drive(1'b1, 1'b0, 3'b010);
    @(negedge clk);
    chk("reset_drop_req", bus.int_req, 3'b000);
    chk("reset_drop_level", bus.level, 3'b000);
    drive(1'b0, 1'b1, 3'b010);
    expect_pulse("after_reset", 3'b011);
    drive(1'b0, 1'b1, 3'b001);
    cycles(W + 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
